// File: rtl/ad9826_serial_responder.sv
// Target-side model of the AD9826 3-wire config port: eight 9-bit registers, serial read/write.
// Optional malformed-frame flag enabled by defining AD9826_FRAME_ERR_EN.
module ad9826_serial_responder #(
  parameter int unsigned SYNC_STAGES = 2,  // minimum 2
  parameter logic [8:0]  REG0_RESET  = 9'h000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        sclk_i,
  input  logic        sload_i,
  input  logic        sdata_i,
  output logic        sdata_o,
  output logic        sdata_oe_o,
  output logic [71:0] regs_o,
  output logic        wr_strobe_o,
  output logic [2:0]  wr_addr_o,
  output logic        frame_err_o
);

  localparam int unsigned S = SYNC_STAGES;

  typedef enum logic [2:0] {StIdle, StAddr, StWdata, StRdata, StDone} state_e;

  // One extra flop on sclk/sload holds the previous synchronized sample for edge detection.
  logic [S:0]   sclk_sync_q, sload_sync_q;
  logic [S-1:0] sdata_sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sclk_sync_q  <= '0;
      sload_sync_q <= '1;
      sdata_sync_q <= '0;
    end else begin
      sclk_sync_q  <= {sclk_sync_q[S-1:0], sclk_i};
      sload_sync_q <= {sload_sync_q[S-1:0], sload_i};
      sdata_sync_q <= {sdata_sync_q[S-2:0], sdata_i};
    end
  end

  logic sclk_rise, sclk_fall, sload_rise, sload_fall, sdata_s;
  assign sclk_rise  =  sclk_sync_q[S-1]  & ~sclk_sync_q[S];
  assign sclk_fall  = ~sclk_sync_q[S-1]  &  sclk_sync_q[S];
  assign sload_rise =  sload_sync_q[S-1] & ~sload_sync_q[S];
  assign sload_fall = ~sload_sync_q[S-1] &  sload_sync_q[S];
  assign sdata_s    =  sdata_sync_q[S-1];

  state_e           state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             rnw_q, rnw_d;
  logic [2:0]       addr_q, addr_d;
  logic [8:0]       hold_q, hold_d;
  logic [8:0]       rd_q, rd_d;
  logic             oe_q, oe_d;
  logic             out_q, out_d;
  logic [7:0][8:0]  regs_q, regs_d;
  logic             wr_strobe_q, wr_strobe_d;
  logic [2:0]       wr_addr_q, wr_addr_d;
`ifdef AD9826_FRAME_ERR_EN
  logic             frame_err_q, frame_err_d;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rnw_d       = rnw_q;
    addr_d      = addr_q;
    hold_d      = hold_q;
    rd_d        = rd_q;
    oe_d        = oe_q;
    out_d       = out_q;
    regs_d      = regs_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
`ifdef AD9826_FRAME_ERR_EN
    frame_err_d = frame_err_q;
`endif
    // Frame end wins over any SCLK edge seen in the same cycle.
    if (sload_rise) begin
      if (state_q != StIdle) begin
        if (!rnw_q && cnt_q == 5'd16) begin
          regs_d[addr_q] = hold_q;
          wr_strobe_d    = 1'b1;
          wr_addr_d      = addr_q;
        end
`ifdef AD9826_FRAME_ERR_EN
        if (cnt_q != 5'd16) frame_err_d = 1'b1;
`endif
      end
      state_d = StIdle;
      oe_d    = 1'b0;
      out_d   = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (sload_fall) begin
            state_d = StAddr;
            cnt_d   = 5'd0;
            rnw_d   = 1'b0;
            addr_d  = 3'd0;
            hold_d  = 9'd0;
          end
        end
        StAddr: begin
          if (sclk_rise) begin
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd0) rnw_d = sdata_s;
            else if (cnt_q <= 5'd3) addr_d = {addr_q[1:0], sdata_s};
            if (cnt_q == 5'd6) begin
              if (rnw_q) begin
                state_d = StRdata;
                rd_d    = regs_q[addr_q];
              end else begin
                state_d = StWdata;
              end
            end
          end
        end
        StWdata: begin
          if (sclk_rise) begin
            cnt_d  = cnt_q + 5'd1;
            hold_d = {hold_q[7:0], sdata_s};
            if (cnt_q == 5'd15) state_d = StDone;
          end
        end
        StRdata: begin
          if (sclk_rise && cnt_q != 5'd16) cnt_d = cnt_q + 5'd1;
          if (sclk_fall) begin
            if (cnt_q == 5'd16) begin
              oe_d    = 1'b0;
              out_d   = 1'b0;
              state_d = StDone;
            end else begin
              oe_d  = 1'b1;
              out_d = rd_q[8];
              rd_d  = {rd_q[7:0], 1'b0};
            end
          end
        end
        StDone: begin
`ifdef AD9826_FRAME_ERR_EN
          if (sclk_rise) frame_err_d = 1'b1;
`endif
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      cnt_q       <= 5'd0;
      rnw_q       <= 1'b0;
      addr_q      <= 3'd0;
      hold_q      <= 9'd0;
      rd_q        <= 9'd0;
      oe_q        <= 1'b0;
      out_q       <= 1'b0;
      regs_q      <= '0;
      regs_q[0]   <= REG0_RESET;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= 3'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rnw_q       <= rnw_d;
      addr_q      <= addr_d;
      hold_q      <= hold_d;
      rd_q        <= rd_d;
      oe_q        <= oe_d;
      out_q       <= out_d;
      regs_q      <= regs_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
    end
  end

`ifdef AD9826_FRAME_ERR_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) frame_err_q <= 1'b0;
    else         frame_err_q <= frame_err_d;
  end
  assign frame_err_o = frame_err_q;
`else
  assign frame_err_o = 1'b0;
`endif

  assign sdata_o     = out_q;
  assign sdata_oe_o  = oe_q;
  assign regs_o      = regs_q;
  assign wr_strobe_o = wr_strobe_q;
  assign wr_addr_o   = wr_addr_q;

endmodule

// File: tb/tb_ad9826_serial_responder.sv
// Randomized bench for ad9826_serial_responder against a frame-level register-file model.
module tb_ad9826_serial_responder;

  typedef logic [7:0][8:0] regfile_t;

  localparam logic [8:0] R0   = 9'h0E8;
  localparam int         HALF = 6;  // SCLK half period in clk cycles

  logic clk = 1'b0, rst_n = 1'b0, sclk = 1'b0, sload = 1'b1, sdata_in = 1'b0;
  logic sdata_out, sdata_oe, wr_strobe, frame_err;
  logic [71:0] regs;
  logic [2:0]  wr_addr;

  int n_tests = 0, n_fail = 0, n_strobes = 0, exp_strobes = 0;
  regfile_t    model_regs, vis_regs;
  logic [2:0]  last_addr = 3'd0;
  logic        err_model = 1'b0;
  logic [11:0] commitq[$];

  ad9826_serial_responder #(
    .SYNC_STAGES(2),
    .REG0_RESET (R0)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .sclk_i     (sclk),
    .sload_i    (sload),
    .sdata_i    (sdata_in),
    .sdata_o    (sdata_out),
    .sdata_oe_o (sdata_oe),
    .regs_o     (regs),
    .wr_strobe_o(wr_strobe),
    .wr_addr_o  (wr_addr),
    .frame_err_o(frame_err)
  );

  always #5 clk = ~clk;

  function automatic regfile_t reset_regs();
    regfile_t r = '0;
    r[0] = R0;
    return r;
  endfunction

  task automatic chk(input string name, input logic [71:0] got, input logic [71:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Per-cycle check: registers change only through expected commits, one strobe per commit.
  always @(negedge clk) begin
    if (!rst_n) begin
      vis_regs = reset_regs();
      commitq.delete();
      chk("rst_regs", regs, vis_regs);
      chk("rst_oe", {71'd0, sdata_oe}, 72'd0);
      chk("rst_strobe", {71'd0, wr_strobe}, 72'd0);
    end else begin
      if (wr_strobe) begin
        n_strobes++;
        if (commitq.size() == 0) begin
          chk("unexpected_strobe", 72'd1, 72'd0);
        end else begin
          logic [11:0] c;
          c = commitq.pop_front();
          chk("strobe_addr", {69'd0, wr_addr}, {69'd0, c[11:9]});
          vis_regs[c[11:9]] = c[8:0];
        end
      end
      chk("regs_cycle", regs, vis_regs);
    end
  end

  task automatic post_checks();
    chk("regs", regs, model_regs);
    chk("strobes", 72'(n_strobes), 72'(exp_strobes));
    chk("commits_done", 72'(commitq.size()), 72'd0);
    chk("wr_addr", {69'd0, wr_addr}, {69'd0, last_addr});
    chk("frame_err", {71'd0, frame_err}, {71'd0, err_model});
    chk("oe_end", {71'd0, sdata_oe}, 72'd0);
  endtask

  // Drives one frame of nbits (1..17); abort_after > 0 pulses reset after that many bits.
  task automatic run_frame(input logic rnw, input logic [2:0] addr, input logic [8:0] data,
                           input int nbits, input int abort_after);
    logic [16:0] bits;
    logic [8:0]  rd_exp;
    bit          aborted;
    aborted = 1'b0;
    bits    = {rnw, addr, 3'($urandom), data, 1'($urandom)};
    rd_exp  = model_regs[addr];
    sload   = 1'b0;
    wait_clk(HALF);
    for (int k = 0; k < nbits; k++) begin
      sdata_in = bits[16-k];
      wait_clk(HALF);
      sclk = 1'b1;
      if (rnw && k >= 7 && k <= 15) begin
        chk("rd_oe", {71'd0, sdata_oe}, 72'd1);
        chk($sformatf("rd_bit%0d", k), {71'd0, sdata_out}, {71'd0, rd_exp[15-k]});
      end else begin
        chk("oe_low", {71'd0, sdata_oe}, 72'd0);
      end
      wait_clk(HALF);
      sclk = 1'b0;
      if (k + 1 == abort_after) begin
        wait_clk(2);
        rst_n = 1'b0;
        #2;
        chk("abort_oe", {71'd0, sdata_oe}, 72'd0);
        sload    = 1'b1;
        sdata_in = 1'b0;
        wait_clk(3);
        model_regs = reset_regs();
        last_addr  = 3'd0;
        err_model  = 1'b0;
        rst_n      = 1'b1;
        wait_clk(4);
        aborted = 1'b1;
        break;
      end
    end
    if (!aborted) begin
      wait_clk(HALF);
      sload = 1'b1;
      if (!rnw && nbits >= 16) begin
        model_regs[addr] = data;
        commitq.push_back({addr, data});
        exp_strobes++;
        last_addr = addr;
      end
`ifdef AD9826_FRAME_ERR_EN
      if (nbits != 16) err_model = 1'b1;
`endif
      wait_clk(10);
    end
    post_checks();
  endtask

  initial begin
    model_regs = reset_regs();
    wait_clk(3);
    chk("lit_reset_r0", {63'd0, regs[8:0]}, {63'd0, 9'h0E8});
    chk("lit_reset_rest", {9'd0, regs[71:9]}, 72'd0);
    chk("lit_reset_oe", {71'd0, sdata_oe}, 72'd0);
    chk("lit_reset_err", {71'd0, frame_err}, 72'd0);
    rst_n = 1'b1;
    wait_clk(3);

    run_frame(1'b0, 3'd0, 9'h0E8, 16, -1);
    chk("lit_w0_strobes", 72'(n_strobes), 72'd1);
    chk("lit_w0_val", {63'd0, regs[8:0]}, {63'd0, 9'h0E8});

    run_frame(1'b0, 3'd5, 9'h1A5, 16, -1);
    chk("lit_w5_val", {63'd0, regs[53:45]}, {63'd0, 9'h1A5});
    run_frame(1'b1, 3'd5, 9'h000, 16, -1);
    chk("lit_r5_unchanged", {63'd0, regs[53:45]}, {63'd0, 9'h1A5});

    run_frame(1'b0, 3'd1, 9'h0AA, 12, -1);
    chk("lit_trunc_strobes", 72'(n_strobes), 72'd2);
    chk("lit_trunc_r1", {63'd0, regs[17:9]}, 72'd0);
`ifdef AD9826_FRAME_ERR_EN
    chk("lit_trunc_err", {71'd0, frame_err}, 72'd1);
`else
    chk("lit_trunc_err", {71'd0, frame_err}, 72'd0);
`endif

    run_frame(1'b0, 3'd3, 9'h0FF, 17, -1);
    chk("lit_long_r3", {63'd0, regs[35:27]}, {63'd0, 9'h0FF});
    chk("lit_long_strobes", 72'(n_strobes), 72'd3);

    run_frame(1'b0, 3'd2, 9'h055, 16, -1);
    chk("lit_pre_r2", {63'd0, regs[26:18]}, {63'd0, 9'h055});
    run_frame(1'b0, 3'd2, 9'h133, 16, 10);
    chk("lit_abort_r2", {63'd0, regs[26:18]}, 72'd0);
    chk("lit_abort_r0", {63'd0, regs[8:0]}, {63'd0, 9'h0E8});
    chk("lit_abort_strobes", 72'(n_strobes), 72'd4);
    chk("lit_abort_err", {71'd0, frame_err}, 72'd0);
    run_frame(1'b0, 3'd2, 9'h133, 16, -1);
    chk("lit_w2_val", {63'd0, regs[26:18]}, {63'd0, 9'h133});
    chk("lit_w2_strobes", 72'(n_strobes), 72'd5);

    for (int i = 0; i < 30; i++) begin
      int nb;
      nb = ($urandom_range(0, 9) < 7) ? 16 : int'($urandom_range(1, 17));
      run_frame(1'($urandom), 3'($urandom), 9'($urandom), nb, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
